interp_datapath: RTL and testbench
==================================

Name: interp_datapath

Overview:
- Transmit-direction counterpart of the CIC/FIR receive datapath. Accepts 8-bit signed samples at the low rate over a valid/ready handshake and buffers them in a small FIFO.
- Produces an upsampled stream by linear interpolation between consecutive samples. Ratio R = 2^interp_ratio output samples per input sample.
- The downstream DAC/modulator pulls each output sample with out_req.

Parameters:
- FIFO_DEPTH, 4, input sample buffer entries (power of 2, >=2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  block enable; low = freeze all state, no handshakes.
- clear  in  1  synchronous flush (FIFO, samples, counters); priority over everything except reset.
- interp_ratio  in  2  unsigned s; R = 2^s (1,2,4,8).
- in_valid  in  1  input sample valid.
- in_data  in  8  signed input sample.
- in_ready  out  1  FIFO can accept; = enable & !full.
- out_req  in  1  request one output sample this cycle.
- out_valid  out  1  out_data valid; one-cycle pulse.
- out_data  out  8  signed interpolated sample.
- underrun  out  1  one-cycle pulse, out_req served with no fresh data.
- underrun_cnt  out  8  saturating count of underrun events.

Behaviour:
- Reset (async): FIFO empty, prev=0, cur=0, k=0, s_lat=0, state IDLE, out_valid=0, out_data=0, underrun=0, underrun_cnt=0.
- Push: in_valid & in_ready writes in_data to FIFO tail. in_ready depends on full only, so no push is accepted when full, even if a pop occurs in the same cycle.
- FSM IDLE: if FIFO non-empty, pop head into cur, k<=0, s_lat<=interp_ratio, go RUN. Pop and out_req can coincide; the request is then served as IDLE.
- FSM RUN, on out_req: out_data <= prev + ((cur-prev)*k >>> s_lat).
  - If k < R-1: k++.
  - Else: prev<=cur. If FIFO non-empty, pop into cur, k<=0, s_lat<=interp_ratio, stay RUN. Otherwise go IDLE.
- IDLE, on out_req: out_data <= prev (hold last value), underrun pulses, underrun_cnt++ (saturates at 255).
- Latency: out_valid and out_data register one cycle after the out_req cycle. out_data holds between requests.
- Arithmetic:
  - diff = cur - prev, 9-bit signed.
  - Product with k (3-bit unsigned) is 12-bit signed.
  - Shift is arithmetic, truncating toward -inf.
  - The sum always lies between prev and cur, so no saturation is needed.
  - R=1 (s=0): out_data = cur's predecessor at k=0; each request emits prev then advances, giving a one-sample delay.
- interp_ratio is sampled only at pop (s_lat). Changes mid-sample take effect on the next sample.
- enable=0: no push, no pop, out_req ignored (out_valid=0, no underrun), all state held. out_data retains its value.
- clear=1: FIFO emptied, prev=cur=0, k=0, IDLE, out_valid=0, underrun=0, underrun_cnt=0. Input and out_req are ignored that cycle.
- Reset or clear mid-sample: discards the partial interpolation and buffered samples. The next output sequence starts from prev=0.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked by an occupancy count, 0..FIFO_DEPTH.

Test Plan:
- s=2, push 40 then -40, out_req every 3 cycles:
  - Output sequence 0,10,20,30,40,20,0,-20.
  - Then IDLE; the next out_req gives -40 with an underrun pulse and underrun_cnt=1.
- s=2, push 7 -> 0,1,3,5. After clear, push -7 -> 0,-2,-4,-6 (checks floor rounding).
- Push 6 samples back-to-back with no out_req, FIFO_DEPTH=4:
  - in_ready drops after 4 accepted (IDLE pops 1, so 5 are accepted in total).
  - Rejected samples are never output.
- Change interp_ratio 2->1 mid-sample: the current sample still emits 4 outputs; the next sample emits 2.
- enable=0 during RUN with out_req held: no out_valid. On re-enable, the sequence resumes at the same k.
- out_req held continuously with an empty FIFO for 300 cycles: underrun pulses each cycle, underrun_cnt saturates at 255. Reset mid-run: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/interp_datapath_if.sv
// interp_datapath_if
//   Sample stream bundle for the transmit interpolator.
//   Input side:  in_valid/in_data/in_ready form a valid/ready push of 8-bit
//                signed low-rate samples.
//   Output side: out_req pulls one upsampled sample; out_valid/out_data answer
//                one cycle later. underrun/underrun_cnt report requests that
//                found no fresh data.
//   master: the producer/consumer outside the interpolator.
//   slave:  the interpolator itself.
interface interp_datapath_if;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              out_req;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              underrun;
    logic [7:0]        underrun_cnt;

    modport master (
        output in_valid, in_data, out_req,
        input  in_ready, out_valid, out_data, underrun, underrun_cnt
    );

    modport slave (
        input  in_valid, in_data, out_req,
        output in_ready, out_valid, out_data, underrun, underrun_cnt
    );
endinterface

// File: rtl/interp_datapath.sv
// interp_datapath
//   Transmit-direction upsampler. Low-rate signed samples are buffered in a
//   small FIFO; each sample is expanded into R = 2^interp_ratio output samples
//   by linear interpolation from the previous sample towards the current one.
//   Ports:
//     clk           rising-edge clock
//     reset         asynchronous active-high reset
//     enable        low freezes all state and ignores handshakes
//     clear         synchronous flush of FIFO, samples and counters
//     interp_ratio  s, R = 2^s; latched when a sample is popped
//     bus           sample stream (slave side of interp_datapath_if)
module interp_datapath #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] interp_ratio,
    interp_datapath_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic signed [7:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    state_t            state_reg;
    logic signed [7:0] prev_reg;
    logic signed [7:0] cur_reg;
    logic [2:0]        k_reg;
    logic [1:0]        s_lat_reg;

    logic              out_valid_reg;
    logic signed [7:0] out_data_reg;
    logic              underrun_reg;
    logic [7:0]        underrun_cnt_reg;

    logic full, empty, active, push, pop, k_last;
    logic [3:0]         r_minus1;
    logic signed [8:0]  diff;
    logic signed [11:0] diff_ext, k_ext, prod, shifted;
    logic signed [7:0]  interp_val;

    assign full   = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_reg == '0);
    assign active = enable & ~clear;

    // in_ready looks at full only, so a pop in the same cycle never makes
    // room for a push.
    assign bus.in_ready = enable & ~full;
    assign push         = active & bus.in_valid & ~full;

    assign r_minus1 = (4'd1 << s_lat_reg) - 4'd1;
    assign k_last   = (k_reg == r_minus1[2:0]);

    // IDLE pops whenever data is waiting; RUN pops only on the request that
    // emits the last phase of the current sample.
    assign pop = active & ~empty &
                 ((state_reg == IDLE) | (bus.out_req & k_last));

    // prev + floor((cur - prev) * k / 2^s). The result always lies between
    // prev and cur, so truncating the sum to 8 bits is exact.
    assign diff       = {cur_reg[7], cur_reg} - {prev_reg[7], prev_reg};
    assign diff_ext   = {{3{diff[8]}}, diff};
    assign k_ext      = {9'd0, k_reg};
    assign prod       = diff_ext * k_ext;
    assign shifted    = prod >>> s_lat_reg;
    assign interp_val = 8'({{4{prev_reg[7]}}, prev_reg} + shifted);

    // Sample storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            state_reg        <= IDLE;
            prev_reg         <= '0;
            cur_reg          <= '0;
            k_reg            <= '0;
            s_lat_reg        <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
        end else if (clear) begin
            // out_data and s_lat are left alone: out_data only changes when a
            // request is served, s_lat is reloaded at the next pop anyway.
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            state_reg        <= IDLE;
            prev_reg         <= '0;
            cur_reg          <= '0;
            k_reg            <= '0;
            out_valid_reg    <= 1'b0;
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
        end else if (!enable) begin
            out_valid_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            underrun_reg  <= 1'b0;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

            case (state_reg)
                IDLE: begin
                    // Nothing being interpolated: repeat the last value.
                    if (bus.out_req) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= prev_reg;
                        underrun_reg  <= 1'b1;
                        if (underrun_cnt_reg != 8'hFF) begin
                            underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
                        end
                    end
                    if (!empty) begin
                        cur_reg   <= mem[rd_ptr_reg];
                        k_reg     <= '0;
                        s_lat_reg <= interp_ratio;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (bus.out_req) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= interp_val;
                        if (!k_last) begin
                            k_reg <= k_reg + 3'd1;
                        end else begin
                            prev_reg <= cur_reg;
                            if (!empty) begin
                                cur_reg   <= mem[rd_ptr_reg];
                                k_reg     <= '0;
                                s_lat_reg <= interp_ratio;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.out_valid    = out_valid_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.underrun     = underrun_reg;
    assign bus.underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_interp_datapath.sv
module tb_interp_datapath;

    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b1;
    logic       clr   = 1'b0;
    logic [1:0] ratio = 2'd0;

    interp_datapath_if dif ();

    interp_datapath #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (en),
        .clear        (clr),
        .interp_ratio (ratio),
        .bus          (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: sample-level view of the interpolator.
    int                mq[$];
    int                m_prev, m_cur, m_k, m_s;
    bit                m_run;
    logic              exp_valid, exp_under, exp_ready;
    logic signed [7:0] exp_data;
    logic [7:0]        exp_cnt;

    function automatic int interp(int p, int c, int k, int s);
        int n, d, q;
        n = (c - p) * k;
        d = 1 << s;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;   // floor, not truncate
        return p + q;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_prev = 0; m_cur = 0; m_k = 0; m_s = 0; m_run = 0;
        exp_valid = 0; exp_under = 0; exp_data = 0; exp_cnt = 0;
        exp_ready = en;
    endtask

    // Predict the outputs after the coming edge from the inputs driven now.
    task automatic model_step();
        bit can_push;
        if (clr) begin
            mq.delete();
            m_prev = 0; m_cur = 0; m_k = 0; m_run = 0;
            exp_valid = 0; exp_under = 0; exp_cnt = 0;
        end else if (!en) begin
            exp_valid = 0; exp_under = 0;
        end else begin
            can_push  = mq.size() < DEPTH;
            exp_valid = 0; exp_under = 0;
            if (!m_run) begin
                if (dif.out_req) begin
                    exp_valid = 1; exp_under = 1; exp_data = 8'(m_prev);
                    if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
                end
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front(); m_k = 0; m_s = ratio; m_run = 1;
                end
            end else if (dif.out_req) begin
                exp_valid = 1;
                exp_data  = 8'(interp(m_prev, m_cur, m_k, m_s));
                if (m_k < (1 << m_s) - 1) begin
                    m_k++;
                end else begin
                    m_prev = m_cur;
                    if (mq.size() > 0) begin
                        m_cur = mq.pop_front(); m_k = 0; m_s = ratio;
                    end else begin
                        m_run = 0;
                    end
                end
            end
            if (dif.in_valid && can_push) mq.push_back(int'(dif.in_data));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        exp_ready = en && (mq.size() < DEPTH);
    endtask

    task automatic test_reset();
        dif.in_valid = 0; dif.in_data = 0; dif.out_req = 0;
        en = 1; clr = 0; ratio = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (dif.out_valid !== 1'b0 || dif.out_data !== 8'sd0 || dif.underrun !== 1'b0 ||
            dif.underrun_cnt !== 8'd0 || dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%0d u=%b cnt=%0d rdy=%b want 0 0 0 0 1",
                     dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready);
        end
    endtask

    task automatic test_ramp();
        logic signed [7:0] got[$];
        int want[9] = '{0, 10, 20, 30, 40, 20, 0, -20, -40};
        ratio = 2;
        for (int i = 0; i < 29; i++) begin
            dif.in_valid = (i < 2);
            dif.in_data  = (i == 0) ? 8'sd40 : -8'sd40;
            dif.out_req  = (i >= 2) && ((i - 2) % 3 == 0);
            tick();
            checks++;
            if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL ramp cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                         cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                         exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
            end
            if (dif.out_valid === 1'b1) got.push_back(dif.out_data);
        end
        dif.in_valid = 0; dif.out_req = 0;
        checks++;
        if (got.size() != 9) begin
            errors++;
            $display("FAIL ramp_count got %0d outputs want 9", got.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (got[i] !== 8'(want[i])) begin
                    errors++;
                    $display("FAIL ramp_seq[%0d] got %0d want %0d", i, got[i], want[i]);
                end
            end
        end
        checks++;
        if (dif.underrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ramp_underrun_cnt got %0d want 1", dif.underrun_cnt);
        end
    endtask

    task automatic test_floor();
        int seeds[2] = '{7, -7};
        int want[2][4] = '{'{0, 1, 3, 5}, '{0, -2, -4, -6}};
        for (int p = 0; p < 2; p++) begin
            logic signed [7:0] got[$];
            for (int i = 0; i < 11; i++) begin
                clr          = (i == 0);
                ratio        = 2;
                dif.in_valid = (i == 1);
                dif.in_data  = 8'(seeds[p]);
                dif.out_req  = (i >= 3) && (i % 2 == 1);
                tick();
                checks++;
                if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                    dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL floor cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                             cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                             exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
                end
                if (dif.out_valid === 1'b1) got.push_back(dif.out_data);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got.size() <= i || got[i] !== 8'(want[p][i])) begin
                    errors++;
                    $display("FAIL floor_seq pass=%0d idx=%0d got %0d want %0d",
                             p, i, (got.size() > i) ? int'(got[i]) : 9999, want[p][i]);
                end
            end
        end
        clr = 0; dif.in_valid = 0; dif.out_req = 0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bit saw_rejected = 0;
        clr = 1; tick(); clr = 0;
        ratio = 1;
        for (int i = 0; i < 19; i++) begin
            dif.in_valid = (i < 6);
            dif.in_data  = 8'(20 * (i + 1));
            dif.out_req  = (i >= 7);
            if (dif.in_valid && dif.in_ready) acc++;
            tick();
            checks++;
            if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                         cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                         exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
            end
            if (dif.out_valid === 1'b1 && dif.out_data === 8'sd120) saw_rejected = 1;
        end
        dif.in_valid = 0; dif.out_req = 0;
        checks++;
        if (acc != 5) begin
            errors++;
            $display("FAIL backpressure_accepted got %0d want 5", acc);
        end
        checks++;
        if (saw_rejected) begin
            errors++;
            $display("FAIL backpressure_rejected_output got 120 on out_data want never");
        end
    endtask

    task automatic test_ratio_change();
        int outs = 0;
        bit hit_underrun = 0;
        clr = 1; tick(); clr = 0;
        ratio = 2;
        for (int i = 0; i < 13; i++) begin
            dif.in_valid = (i < 2);
            dif.in_data  = (i == 0) ? 8'sd50 : 8'sd90;
            dif.out_req  = (i >= 3);
            if (i == 5) ratio = 1;
            tick();
            checks++;
            if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL ratio_change cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                         cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                         exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
            end
            if (dif.underrun === 1'b1) hit_underrun = 1;
            if (!hit_underrun && dif.out_valid === 1'b1) outs++;
        end
        dif.in_valid = 0; dif.out_req = 0;
        checks++;
        if (outs != 6) begin
            errors++;
            $display("FAIL ratio_change_outputs got %0d want 6", outs);
        end
    endtask

    task automatic test_enable();
        logic signed [7:0] first_after = 0;
        bit seen = 0;
        clr = 1; tick(); clr = 0;
        ratio = 2;
        for (int i = 0; i < 12; i++) begin
            en           = !(i >= 4 && i < 8);
            dif.in_valid = (i == 0) || !en;
            dif.in_data  = (i == 0) ? 8'sd80 : -8'sd100;
            dif.out_req  = (i >= 2);
            tick();
            checks++;
            if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL enable cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                         cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                         exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
            end
            if (i >= 8 && !seen && dif.out_valid === 1'b1) begin
                first_after = dif.out_data;
                seen = 1;
            end
        end
        en = 1; dif.in_valid = 0; dif.out_req = 0;
        checks++;
        if (!seen || first_after !== 8'sd40) begin
            errors++;
            $display("FAIL enable_resume got seen=%0d d=%0d want d=40", seen, first_after);
        end
    endtask

    task automatic test_random();
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 500; i++) begin
            en           = ($urandom_range(0, 9) != 0);
            clr          = ($urandom_range(0, 99) == 0);
            ratio        = 2'($urandom_range(0, 3));
            dif.in_valid = ($urandom_range(0, 1) == 1);
            dif.in_data  = 8'($urandom);
            dif.out_req  = ($urandom_range(0, 9) < 4);
            tick();
            checks++;
            if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL random cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                         cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                         exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
            end
        end
        en = 1; clr = 0; dif.in_valid = 0; dif.out_req = 0;
    endtask

    task automatic test_saturate();
        clr = 1; tick(); clr = 0;
        dif.in_valid = 0;
        dif.out_req  = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
                dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL saturate cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                         cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                         exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
            end
        end
        checks++;
        if (dif.underrun_cnt !== 8'd255 || dif.underrun !== 1'b1) begin
            errors++;
            $display("FAIL saturate_final got cnt=%0d u=%b want cnt=255 u=1",
                     dif.underrun_cnt, dif.underrun);
        end
        // Reset between clock edges must take effect immediately.
        #2;
        reset = 1;
        #1;
        checks++;
        if (dif.out_valid !== 1'b0 || dif.out_data !== 8'sd0 || dif.underrun !== 1'b0 ||
            dif.underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%0d u=%b cnt=%0d want 0 0 0 0",
                     dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        dif.out_req = 0;
        tick();
        checks++;
        if (dif.out_valid !== exp_valid || dif.out_data !== exp_data || dif.underrun !== exp_under ||
            dif.underrun_cnt !== exp_cnt || dif.in_ready !== exp_ready) begin
            errors++;
            $display("FAIL post_reset cyc=%0d got v=%b d=%0d u=%b cnt=%0d rdy=%b want v=%b d=%0d u=%b cnt=%0d rdy=%b",
                     cyc, dif.out_valid, dif.out_data, dif.underrun, dif.underrun_cnt, dif.in_ready,
                     exp_valid, exp_data, exp_under, exp_cnt, exp_ready);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_floor();
        test_backpressure();
        test_ratio_change();
        test_enable();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
